motor_arm_sequencer: RTL and testbench
======================================

Name: motor_arm_sequencer

Overview:
- Safety sequencer between the four motor_offset_summer outputs and the four pwm_generator inputs.
- Gates motor commands behind a stick-gesture arm/disarm state machine.
- Ramps motors up to idle on arming.
- Runs a receiver-link watchdog. On link loss it forces a controlled ramp-down (failsafe) and then disarms.

Parameters:
- HOLD_CYCLES, 1024: consecutive cycles an arm/disarm gesture must be held.
- TIMEOUT_CYCLES, 65536: maximum cycles between rx_valid pulses before the link counts as lost.
- RAMP_DIV, 64: cycles per 1-LSB ramp step (spin-up and failsafe descent).
- IDLE_CMD, 8'd20: minimum motor command while armed.
- THR_LOW, 8'd10: throttle at or below this value counts as low.
- YAW_HIGH, 8'd245: yaw at or above this value is the arm gesture.
- YAW_LOW, 8'd10: yaw at or below this value is the disarm gesture.

Ports:
- clk, in, 1: system clock (single domain).
- rst, in, 1: asynchronous, active-high reset.
- rx_valid, in, 1: one-cycle pulse each time the receiver readers refresh.
- throttle_in, in, 8: decoded throttle stick value.
- yaw_in, in, 8: decoded yaw stick value.
- m1_in..m4_in, in, 8 each: summed motor commands.
- m1_out..m4_out, out, 8 each: gated commands to the pwm generators.
- armed, out, 1: high in SPINUP, ARMED and DISARMING.
- failsafe, out, 1: sticky failsafe indicator.

Behaviour:
- Reset (async, rst=1):
  - state=DISARMED; all m*_out=0; armed=0; failsafe=0.
  - hold_cnt=0; ramp prescaler=0.
  - Watchdog counter=TIMEOUT_CYCLES, so the link is lost until the first rx_valid.
- Watchdog:
  - Counter clears to 0 on a cycle with rx_valid=1; otherwise increments, saturating at TIMEOUT_CYCLES.
  - link_ok = (counter < TIMEOUT_CYCLES).
- Gestures (combinational on inputs):
  - arm_g = link_ok & throttle_in<=THR_LOW & yaw_in>=YAW_HIGH.
  - disarm_g = throttle_in<=THR_LOW & yaw_in<=YAW_LOW.
- All outputs are registered. The ramp prescaler and hold_cnt clear on every state transition.
- DISARMED: outputs 0. arm_g -> ARMING.
- ARMING:
  - Outputs 0; hold_cnt increments per cycle.
  - !arm_g -> DISARMED.
  - hold_cnt==HOLD_CYCLES-1 with arm_g -> SPINUP. The failsafe flag clears on this transition.
- SPINUP:
  - All four outputs equal a shared ramp register, starting at 0 and incrementing by 1 every RAMP_DIV cycles.
  - Ramp==IDLE_CMD -> ARMED.
  - !link_ok -> FAILSAFE (takes priority).
- ARMED:
  - mN_out = max(mN_in, IDLE_CMD), with 1-cycle latency from mN_in.
  - !link_ok -> FAILSAFE. Else disarm_g -> DISARMING.
- DISARMING:
  - Outputs as in ARMED; hold_cnt increments.
  - !link_ok -> FAILSAFE.
  - !disarm_g -> ARMED.
  - hold_cnt==HOLD_CYCLES-1 -> DISARMED; outputs 0 on the next cycle.
- FAILSAFE:
  - failsafe=1; armed=0.
  - Each output independently holds its entry value, then decrements by 1 every RAMP_DIV cycles, saturating at 0. Inputs are ignored.
  - All four outputs ==0 -> DISARMED. failsafe stays 1 until the next ARMING->SPINUP transition.
  - Link restoration during FAILSAFE does not abort the descent.
- Priority: link loss > disarm gesture > command pass-through.
- Reset mid-operation: outputs go to 0 immediately (asynchronously); no ramp-down.
- Widths:
  - hold_cnt is $clog2(HOLD_CYCLES) bits; the watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits.
  - The max() compare is unsigned 8-bit.
  - No arithmetic wraps: the ramp never exceeds IDLE_CMD and the descent saturates at 0.

Test Plan (HOLD_CYCLES=8, TIMEOUT_CYCLES=32, RAMP_DIV=2, IDLE_CMD=4; rx_valid pulsed every 10 cycles unless stated):
- Arm success: throttle=5, yaw=250 held for 8 cycles -> SPINUP, armed=1. Outputs step 0,1,2,3,4 every 2 cycles, then ARMED.
- Arm abort: throttle=5, yaw=250 for 5 cycles, then yaw=128 -> DISARMED, outputs stay 0, armed=0.
- Pass-through and floor: ARMED with m1_in=100, m2_in=2, m3_in=4, m4_in=255 -> next cycle outputs 100, 4, 4, 255.
- Link loss: ARMED with outputs 100/4/4/255, rx_valid stopped -> FAILSAFE 32 cycles after the last pulse, failsafe=1. Each output decrements 1 per 2 cycles; DISARMED once all reach 0 (510 cycles after entry). failsafe stays 1.
- Disarm: ARMED, throttle=5, yaw=3 for 8 cycles -> DISARMED, outputs 0, armed=0. The same gesture held only 7 cycles -> returns to ARMED.
- No link at power-up: no rx_valid ever, throttle=5, yaw=250 held for 100 cycles -> stays DISARMED, outputs 0. Async rst asserted while ARMED -> outputs 0 within the same cycle.

Source files
------------

// File: rtl/motor_arm_if.sv
// Bundle between the motor mixer / receiver decode and the arm sequencer.
// The master drives sticks, link pulse and summed commands; the slave returns gated commands.
interface motor_arm_if;
    logic       rx_valid;
    logic [7:0] throttle_in;
    logic [7:0] yaw_in;
    logic [7:0] m1_in;
    logic [7:0] m2_in;
    logic [7:0] m3_in;
    logic [7:0] m4_in;
    logic [7:0] m1_out;
    logic [7:0] m2_out;
    logic [7:0] m3_out;
    logic [7:0] m4_out;
    logic       armed;
    logic       failsafe;

    modport master (
        output rx_valid, throttle_in, yaw_in, m1_in, m2_in, m3_in, m4_in,
        input  m1_out, m2_out, m3_out, m4_out, armed, failsafe
    );

    modport slave (
        input  rx_valid, throttle_in, yaw_in, m1_in, m2_in, m3_in, m4_in,
        output m1_out, m2_out, m3_out, m4_out, armed, failsafe
    );
endinterface

// File: rtl/motor_arm_sequencer.sv
// Motor arm/disarm safety sequencer: stick-gesture arming, spin-up ramp to idle,
// receiver-link watchdog with controlled failsafe descent.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// DISARMED    | motors off, waiting for arm gesture
// ARMING      | arm gesture being held, counting hold cycles
// SPINUP      | all motors follow shared ramp up to IDLE_CMD
// ARMED       | commands passed through with IDLE_CMD floor
// DISARMING   | disarm gesture being held, commands still passed through
// FAILSAFE    | link lost, each motor descends from its entry value to 0
module motor_arm_sequencer #(
    parameter int         HOLD_CYCLES    = 1024,
    parameter int         TIMEOUT_CYCLES = 65536,
    parameter int         RAMP_DIV       = 64,
    parameter logic [7:0] IDLE_CMD       = 8'd20,
    parameter logic [7:0] THR_LOW        = 8'd10,
    parameter logic [7:0] YAW_HIGH       = 8'd245,
    parameter logic [7:0] YAW_LOW        = 8'd10
) (
    input logic        clk,
    input logic        rst,
    motor_arm_if.slave bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);

    typedef enum logic [2:0] {
        S_DISARMED, S_ARMING, S_SPINUP, S_ARMED, S_DISARMING, S_FAILSAFE
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      ramp_q, ramp_d;
    logic [3:0][7:0] m_q, m_d, m_in, m_pass;
    logic            fs_q, fs_d;
    logic            armed_q, armed_d;
    logic [WW-1:0]   wd_q;
    logic            link_ok, arm_g, disarm_g, step;

    // Watchdog starts saturated so the link reads lost until the first refresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_q <= WD_MAX;
        else if (bus.rx_valid)
            wd_q <= '0;
        else if (wd_q != WD_MAX)
            wd_q <= wd_q + WW'(1);
    end

    assign link_ok  = (wd_q < WD_MAX);
    assign arm_g    = link_ok && (bus.throttle_in <= THR_LOW) && (bus.yaw_in >= YAW_HIGH);
    assign disarm_g = (bus.throttle_in <= THR_LOW) && (bus.yaw_in <= YAW_LOW);
    assign step     = (presc_q == PRESC_LAST);
    assign m_in     = {bus.m4_in, bus.m3_in, bus.m2_in, bus.m1_in};

    always_comb begin
        for (int i = 0; i < 4; i++)
            m_pass[i] = (m_in[i] < IDLE_CMD) ? IDLE_CMD : m_in[i];
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        presc_d = presc_q;
        ramp_d  = ramp_q;
        m_d     = m_q;
        fs_d    = fs_q;
        case (state_q)
            S_DISARMED: begin
                m_d = '0;
                if (arm_g) state_d = S_ARMING;
            end
            S_ARMING: begin
                m_d    = '0;
                hold_d = hold_q + HW'(1);
                if (!arm_g) begin
                    state_d = S_DISARMED;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_SPINUP;
                    ramp_d  = '0;
                    fs_d    = 1'b0;
                end
            end
            S_SPINUP: begin
                presc_d = step ? '0 : presc_q + PW'(1);
                if (step && ramp_q < IDLE_CMD) ramp_d = ramp_q + 8'd1;
                m_d = {4{ramp_d}};
                if (!link_ok) begin
                    state_d = S_FAILSAFE;
                    m_d     = m_q;
                    fs_d    = 1'b1;
                end else if (ramp_q == IDLE_CMD) begin
                    state_d = S_ARMED;
                    m_d     = m_pass;
                end
            end
            S_ARMED: begin
                m_d = m_pass;
                if (!link_ok) begin
                    state_d = S_FAILSAFE;
                    m_d     = m_q;
                    fs_d    = 1'b1;
                end else if (disarm_g) begin
                    state_d = S_DISARMING;
                end
            end
            S_DISARMING: begin
                m_d    = m_pass;
                hold_d = hold_q + HW'(1);
                if (!link_ok) begin
                    state_d = S_FAILSAFE;
                    m_d     = m_q;
                    fs_d    = 1'b1;
                end else if (!disarm_g) begin
                    state_d = S_ARMED;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_DISARMED;
                    m_d     = '0;
                end
            end
            S_FAILSAFE: begin
                presc_d = step ? '0 : presc_q + PW'(1);
                if (step) begin
                    for (int i = 0; i < 4; i++)
                        m_d[i] = (m_q[i] != 8'd0) ? m_q[i] - 8'd1 : 8'd0;
                end
                if (m_q == '0) state_d = S_DISARMED;
            end
            default: begin
                state_d = S_DISARMED;
                m_d     = '0;
            end
        endcase
        if (state_d != state_q) begin
            hold_d  = '0;
            presc_d = '0;
        end
        armed_d = (state_d == S_SPINUP) || (state_d == S_ARMED) || (state_d == S_DISARMING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_DISARMED;
            hold_q  <= '0;
            presc_q <= '0;
            ramp_q  <= '0;
            m_q     <= '0;
            fs_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            presc_q <= presc_d;
            ramp_q  <= ramp_d;
            m_q     <= m_d;
            fs_q    <= fs_d;
            armed_q <= armed_d;
        end
    end

    assign bus.m1_out   = m_q[0];
    assign bus.m2_out   = m_q[1];
    assign bus.m3_out   = m_q[2];
    assign bus.m4_out   = m_q[3];
    assign bus.armed    = armed_q;
    assign bus.failsafe = fs_q;
endmodule

// File: tb/tb_motor_arm_sequencer.sv
// Self-checking bench for motor_arm_sequencer: directed scenarios plus randomized
// stick/link stimulus against an elapsed-time reference model.
module tb_motor_arm_sequencer;
    localparam int         HOLD     = 8;
    localparam int         TMO      = 32;
    localparam int         DIV      = 2;
    localparam logic [7:0] IDLE     = 8'd4;
    localparam logic [7:0] THR_LOW  = 8'd10;
    localparam logic [7:0] YAW_HIGH = 8'd245;
    localparam logic [7:0] YAW_LOW  = 8'd10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    motor_arm_if bus();

    motor_arm_sequencer #(
        .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .RAMP_DIV(DIV), .IDLE_CMD(IDLE),
        .THR_LOW(THR_LOW), .YAW_HIGH(YAW_HIGH), .YAW_LOW(YAW_LOW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rx_en    = 1'b0;

    // Reference model: phase plus edges elapsed in that phase; outputs are
    // derived arithmetically from elapsed time and entry values.
    typedef enum {P_DIS, P_ARMING, P_SPIN, P_ARMED, P_DISARMING, P_FS} phase_t;
    phase_t ph;
    int     k;
    int     since;
    int     ex[4];
    int     entry[4];
    bit     ex_fs;

    function automatic void model_reset();
        ph    = P_DIS;
        k     = 0;
        since = TMO;
        ex_fs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex[i]    = 0;
            entry[i] = 0;
        end
    endfunction

    function automatic void model_step();
        int     ins[4];
        bit     link, arm_g, disarm_g, all_zero;
        phase_t nph;
        ins[0]   = int'(bus.m1_in);
        ins[1]   = int'(bus.m2_in);
        ins[2]   = int'(bus.m3_in);
        ins[3]   = int'(bus.m4_in);
        link     = (since < TMO);
        arm_g    = link && (bus.throttle_in <= THR_LOW) && (bus.yaw_in >= YAW_HIGH);
        disarm_g = (bus.throttle_in <= THR_LOW) && (bus.yaw_in <= YAW_LOW);
        all_zero = (ex[0] == 0) && (ex[1] == 0) && (ex[2] == 0) && (ex[3] == 0);
        nph = ph;
        case (ph)
            P_DIS:       if (arm_g) nph = P_ARMING;
            P_ARMING:    if (!arm_g) nph = P_DIS; else if (k == HOLD - 1) nph = P_SPIN;
            P_SPIN:      if (!link) nph = P_FS; else if (ex[0] == int'(IDLE)) nph = P_ARMED;
            P_ARMED:     if (!link) nph = P_FS; else if (disarm_g) nph = P_DISARMING;
            P_DISARMING: if (!link) nph = P_FS; else if (!disarm_g) nph = P_ARMED;
                         else if (k == HOLD - 1) nph = P_DIS;
            P_FS:        if (all_zero) nph = P_DIS;
            default:     nph = P_DIS;
        endcase
        k = (nph == ph) ? k + 1 : 0;
        if (nph == P_FS && ph != P_FS) begin
            for (int i = 0; i < 4; i++) entry[i] = ex[i];
            ex_fs = 1'b1;
        end
        if (nph == P_SPIN && ph == P_ARMING) ex_fs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (nph)
                P_SPIN:                ex[i] = (k / DIV < int'(IDLE)) ? k / DIV : int'(IDLE);
                P_ARMED, P_DISARMING:  ex[i] = (ins[i] < int'(IDLE)) ? int'(IDLE) : ins[i];
                P_FS:                  ex[i] = (entry[i] - k / DIV > 0) ? entry[i] - k / DIV : 0;
                default:               ex[i] = 0;
            endcase
        end
        ph    = nph;
        since = bus.rx_valid ? 0 : ((since < TMO) ? since + 1 : TMO);
    endfunction

    function automatic logic [33:0] exp_vec();
        logic ea;
        ea = (ph == P_SPIN) || (ph == P_ARMED) || (ph == P_DISARMING);
        return {8'(ex[0]), 8'(ex[1]), 8'(ex[2]), 8'(ex[3]), ea, ex_fs};
    endfunction

    function automatic logic [33:0] dut_vec();
        return {bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out, bus.armed, bus.failsafe};
    endfunction

    task automatic tick();
        bus.rx_valid = rx_en && (cyc % 10 == 0);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic neutral_sticks();
        bus.throttle_in = 8'd128;
        bus.yaw_in      = 8'd128;
    endtask

    task automatic arm_up();
        bus.throttle_in = 8'd5;
        bus.yaw_in      = 8'd250;
        for (int n = 0; n < 100 && ph != P_ARMED; n++) tick();
        neutral_sticks();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out} !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=00000000", {bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out});
        end
        checks++;
        if (bus.armed !== 1'b0) begin
            failures++;
            $display("FAIL reset_armed got=%b exp=0", bus.armed);
        end
        checks++;
        if (bus.failsafe !== 1'b0) begin
            failures++;
            $display("FAIL reset_failsafe got=%b exp=0", bus.failsafe);
        end
    endtask

    task automatic test_arm();
        int t_armed;
        t_armed = -1;
        do_reset();
        rx_en = 1'b1;
        tick();
        bus.throttle_in = 8'd5;
        bus.yaw_in      = 8'd250;
        for (int n = 1; n <= 30; n++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL arm_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (t_armed < 0 && bus.armed === 1'b1) t_armed = n;
        end
        checks++;
        if (t_armed != HOLD + 1) begin
            failures++;
            $display("FAIL arm_latency got=%0d exp=%0d", t_armed, HOLD + 1);
        end
        neutral_sticks();
    endtask

    task automatic test_arm_abort();
        do_reset();
        rx_en = 1'b1;
        tick();
        bus.throttle_in = 8'd5;
        bus.yaw_in      = 8'd250;
        repeat (5) tick();
        bus.yaw_in = 8'd128;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if ({dut_vec(), 1'b0} !== 35'h0 || dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL arm_abort cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_passthrough();
        bus.m1_in = 8'd100;
        bus.m2_in = 8'd2;
        bus.m3_in = 8'd4;
        bus.m4_in = 8'd255;
        tick();
        checks++;
        if ({bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out} !== {8'd100, 8'd4, 8'd4, 8'd255}) begin
            failures++;
            $display("FAIL pass_floor got=%h exp=640404ff", {bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out});
        end
        for (int n = 0; n < 30; n++) begin
            bus.m1_in       = 8'($urandom);
            bus.m2_in       = 8'($urandom_range(0, 8));
            bus.m3_in       = 8'($urandom);
            bus.m4_in       = 8'($urandom_range(0, 8));
            bus.throttle_in = 8'($urandom_range(11, 255));
            bus.yaw_in      = 8'($urandom);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL pass_random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        neutral_sticks();
    endtask

    task automatic test_disarm();
        tick();
        bus.throttle_in = 8'd5;
        bus.yaw_in      = 8'd3;
        repeat (HOLD) tick();
        neutral_sticks();
        repeat (3) tick();
        checks++;
        if (bus.armed !== 1'b1 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL disarm_short got=%h exp=%h", dut_vec(), exp_vec());
        end
        bus.throttle_in = 8'd5;
        bus.yaw_in      = 8'd3;
        repeat (HOLD + 1) tick();
        neutral_sticks();
        checks++;
        if (bus.armed !== 1'b0 || {bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out} !== 32'h0) begin
            failures++;
            $display("FAIL disarm_full armed=%b outs=%h exp armed=0 outs=00000000",
                     bus.armed, {bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out});
        end
    endtask

    task automatic test_link_loss();
        int fs_t, z_t;
        fs_t = -1;
        z_t  = -1;
        do_reset();
        rx_en = 1'b1;
        tick();
        arm_up();
        bus.m1_in = 8'd100;
        bus.m2_in = 8'd2;
        bus.m3_in = 8'd4;
        bus.m4_in = 8'd255;
        tick();
        rx_en = 1'b0;
        for (int n = 0; n < 620; n++) begin
            if (fs_t >= 0 && n == fs_t + 100) rx_en = 1'b1;
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL link_loss cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (fs_t < 0 && bus.failsafe === 1'b1) fs_t = n;
            if (fs_t >= 0 && z_t < 0 && {bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out} === 32'h0) z_t = n;
        end
        checks++;
        if (fs_t < 0 || z_t - fs_t != 255 * DIV) begin
            failures++;
            $display("FAIL descent_len got=%0d exp=%0d", z_t - fs_t, 255 * DIV);
        end
        checks++;
        if (bus.failsafe !== 1'b1 || bus.armed !== 1'b0) begin
            failures++;
            $display("FAIL failsafe_sticky got fs=%b armed=%b exp fs=1 armed=0", bus.failsafe, bus.armed);
        end
    endtask

    task automatic test_rearm_clears_failsafe();
        bus.m1_in = 8'd0;
        bus.m2_in = 8'd0;
        bus.m3_in = 8'd0;
        bus.m4_in = 8'd0;
        repeat (12) tick();
        arm_up();
        checks++;
        if (bus.failsafe !== 1'b0 || bus.armed !== 1'b1 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL rearm got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_no_link();
        do_reset();
        rx_en = 1'b0;
        bus.throttle_in = 8'd5;
        bus.yaw_in      = 8'd250;
        for (int n = 0; n < 100; n++) begin
            tick();
            checks++;
            if (dut_vec() !== 34'h0 || dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL no_link cyc=%0d got=%h exp=0", cyc, dut_vec());
            end
        end
        neutral_sticks();
    endtask

    task automatic test_async_reset();
        do_reset();
        rx_en = 1'b1;
        tick();
        arm_up();
        bus.m1_in = 8'd50;
        bus.m2_in = 8'd60;
        bus.m3_in = 8'd70;
        bus.m4_in = 8'd80;
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out, bus.armed} !== 33'h0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", {bus.m1_out, bus.m2_out, bus.m3_out, bus.m4_out, bus.armed});
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            if ($urandom_range(0, 11) == 0) begin
                rx_en = 1'b0;
                len   = $urandom_range(40, 70);
            end else begin
                rx_en = 1'b1;
                len   = $urandom_range(1, 20);
            end
            bus.throttle_in = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            case ($urandom_range(0, 2))
                0:       bus.yaw_in = 8'($urandom_range(245, 255));
                1:       bus.yaw_in = 8'($urandom_range(0, 10));
                default: bus.yaw_in = 8'($urandom);
            endcase
            for (int n = 0; n < len; n++) begin
                bus.m1_in = 8'($urandom);
                bus.m2_in = 8'($urandom);
                bus.m3_in = 8'($urandom);
                bus.m4_in = 8'($urandom_range(0, 8));
                tick();
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.m1_in    = 8'd0;
        bus.m2_in    = 8'd0;
        bus.m3_in    = 8'd0;
        bus.m4_in    = 8'd0;
        neutral_sticks();
        model_reset();
        test_reset();
        test_arm();
        test_passthrough();
        test_disarm();
        test_arm_abort();
        test_link_loss();
        test_rearm_clears_failsafe();
        test_no_link();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
